icache_l1: RTL and testbench
============================

ICACHE_L1 -- requirements
Module: icache_l1

Interface
REQ-001 Parameter LINES, default 64, number of direct-mapped cache lines (power of two).
REQ-002 Parameter WORDS, default 4, 32-bit words per line (fixed at 4 for this release).
REQ-003 Reset polarity: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 inst_read_i  input  1  CPU fetch request, level, held while stallreq_o=1.
REQ-007 inst_addr_i  input  32  CPU fetch byte address (word aligned), held while stallreq_o=1.
REQ-008 inst_out_o  output  32  fetched instruction, valid when inst_read_i=1 and stallreq_o=0.
REQ-009 stallreq_o  output  1  CPU stall request (drives the CPU stallreq_from_imem input).
REQ-010 flush_i  input  1  one-cycle pulse, invalidate entire cache.
REQ-011 mem_req_o  output  1  line-refill request to memory.
REQ-012 mem_addr_o  output  32  refill line address, bits [3:0]=0.
REQ-013 mem_gnt_i  input  1  memory accepts request this cycle.
REQ-014 mem_rvalid_i  input  1  refill data beat valid.
REQ-015 mem_rdata_i  input  32  refill data beat.
REQ-016 hit_cnt_o  output  32  count of hit cycles.
REQ-017 miss_cnt_o  output  32  count of misses (refills started).

Function
REQ-018 Address split: offset [3:2], index [log2(LINES)+3:4], tag = remaining upper bits (22 bits at LINES=64).
REQ-019 Storage: per line a valid bit, tag, WORDS x 32 data, all flip-flops; lookup is combinational, same cycle.
REQ-020 Hit = inst_read_i & state IDLE & valid[index] & tag match; on hit inst_out_o = data word, stallreq_o=0, zero-cycle latency.
REQ-021 inst_read_i=0: no lookup, stallreq_o=0, counters unchanged, inst_out_o=0.
REQ-022 FSM states IDLE, REQ, FILL, DONE.
REQ-023 IDLE: on miss, stallreq_o=1 combinationally, miss_cnt_o+1, capture line address, go REQ.
REQ-024 REQ: mem_req_o=1, mem_addr_o = {tag,index,4'b0}; held stable until mem_gnt_i=1, then go FILL.
REQ-025 FILL: each mem_rvalid_i=1 writes mem_rdata_i into word beat_cnt (0,1,2,3 in order), beat_cnt+1; cycles with mem_rvalid_i=0 wait; stallreq_o=1.
REQ-026 Last beat: set valid[index], write tag, go DONE.
REQ-027 DONE: one cycle, stallreq_o=0, inst_out_o = word at captured offset; hit_cnt_o not incremented; next state IDLE.
REQ-028 mem_rvalid_i outside FILL is ignored.
REQ-029 Minimum miss penalty: 1 (IDLE) + 1 (REQ with immediate gnt) + 4 (FILL) stall cycles, instruction delivered in DONE.
REQ-030 flush_i in IDLE clears all valid bits at the next edge; a lookup in the same cycle still uses pre-flush state.
REQ-031 flush_i in REQ/FILL/DONE sets pending flag; the refilling line is still marked valid, then all valid bits and the flag clear on the first IDLE cycle.
REQ-032 hit_cnt_o and miss_cnt_o wrap modulo 2^32.
REQ-033 Index alias (same index, different tag) replaces the line; no write path from CPU exists.

Reset
REQ-034 rst=1 asynchronously: state IDLE, all valid bits 0, pending flush 0, beat_cnt 0, counters 0, mem_req_o=0, mem_addr_o=0, stallreq_o=0; data/tag arrays need not reset.
REQ-035 Reset during REQ/FILL abandons the refill; late rvalid beats are ignored; the line stays invalid.

Verification
REQ-036 After reset, read 0x0000_0100 with gnt in REQ and 4 back-to-back beats 0xA0..0xA3 -> stallreq_o high 6 cycles, mem_addr_o=0x100, DONE outputs 0xA0, miss_cnt_o=1.
REQ-037 Then read 0x104,0x108,0x10C on consecutive cycles -> outputs 0xA1,0xA2,0xA3, stallreq_o=0, hit_cnt_o=3.
REQ-038 Read 0x0000_0500 (same index 0x10, new tag) -> refill at 0x500; subsequent read 0x100 misses again.
REQ-039 gnt delayed 3 cycles and rvalid gaps of 2 cycles -> mem_req_o/mem_addr_o stable until gnt, words land in order, stall lasts exactly until last beat +1.
REQ-040 flush_i during FILL -> refill completes and DONE delivers word; next IDLE clears all; repeat of same address misses.
REQ-041 rst asserted after 2 FILL beats -> mem_req_o=0, state IDLE; remaining beats ignored; same address misses with full refill.

Source files
------------

// File: rtl/icache_l1.sv
// Direct-mapped, flip-flop based L1 instruction cache with a four-beat line refill.
// Hits are combinational in IDLE; misses stall the CPU through REQ and FILL and return the word in DONE.
module icache_l1 #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_read_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_out_o,
  output logic        stallreq_o,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);

  localparam int IDXW  = $clog2(LINES);
  localparam int BEATW = $clog2(WORDS);
  localparam int TAGW  = 32 - IDXW - 4;

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_e;

  state_e                  state_q, state_d;
  logic [LINES-1:0]        valid_q, valid_d;
  logic                    flushPend_q, flushPend_d;
  logic [BEATW-1:0]        beatCnt_q, beatCnt_d;
  logic [31:0]             lineAddr_q, lineAddr_d;
  logic [BEATW-1:0]        offset_q, offset_d;
  logic [31:0]             hitCnt_q, hitCnt_d;
  logic [31:0]             missCnt_q, missCnt_d;

  logic [TAGW-1:0]         tagArr_q  [LINES];
  logic [31:0]             dataArr_q [LINES][WORDS];

  logic [IDXW-1:0]         reqIdx, fillIdx;
  logic [TAGW-1:0]         reqTag, fillTag;
  logic [BEATW-1:0]        reqOff;
  logic                    hit, fillWe, lastBeat;
  logic                    unusedAddrBits;

  assign reqIdx   = inst_addr_i[IDXW+3:4];
  assign reqTag   = inst_addr_i[31:IDXW+4];
  assign reqOff   = inst_addr_i[BEATW+1:2];
  assign fillIdx  = lineAddr_q[IDXW+3:4];
  assign fillTag  = lineAddr_q[31:IDXW+4];
  assign lastBeat = (beatCnt_q == BEATW'(WORDS - 1));
  assign unusedAddrBits = ^inst_addr_i[1:0];

  assign hit = inst_read_i && (state_q == IDLE) && valid_q[reqIdx] &&
               (tagArr_q[reqIdx] == reqTag);

  assign mem_addr_o = lineAddr_q;
  assign hit_cnt_o  = hitCnt_q;
  assign miss_cnt_o = missCnt_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    flushPend_d = flushPend_q;
    beatCnt_d   = beatCnt_q;
    lineAddr_d  = lineAddr_q;
    offset_d    = offset_q;
    hitCnt_d    = hitCnt_q;
    missCnt_d   = missCnt_q;
    inst_out_o  = '0;
    stallreq_o  = 1'b0;
    mem_req_o   = 1'b0;
    fillWe      = 1'b0;

    // A flush seen mid-refill is deferred so the line being filled still lands first.
    if (state_q != IDLE && flush_i) begin
      flushPend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (flush_i || flushPend_q) begin
          valid_d     = '0;
          flushPend_d = 1'b0;
        end
        if (inst_read_i) begin
          if (hit) begin
            inst_out_o = dataArr_q[reqIdx][reqOff];
            hitCnt_d   = hitCnt_q + 32'd1;
          end else begin
            stallreq_o = 1'b1;
            missCnt_d  = missCnt_q + 32'd1;
            lineAddr_d = {inst_addr_i[31:4], 4'b0000};
            offset_d   = reqOff;
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        stallreq_o = 1'b1;
        mem_req_o  = 1'b1;
        if (mem_gnt_i) begin
          beatCnt_d = '0;
          state_d   = FILL;
        end
      end
      FILL: begin
        stallreq_o = 1'b1;
        if (mem_rvalid_i) begin
          fillWe    = 1'b1;
          beatCnt_d = beatCnt_q + BEATW'(1);
          if (lastBeat) begin
            valid_d[fillIdx] = 1'b1;
            state_d          = DONE;
          end
        end
      end
      DONE: begin
        if (inst_read_i) begin
          inst_out_o = dataArr_q[fillIdx][offset_q];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      flushPend_q <= 1'b0;
      beatCnt_q   <= '0;
      lineAddr_q  <= '0;
      offset_q    <= '0;
      hitCnt_q    <= '0;
      missCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      flushPend_q <= flushPend_d;
      beatCnt_q   <= beatCnt_d;
      lineAddr_q  <= lineAddr_d;
      offset_q    <= offset_d;
      hitCnt_q    <= hitCnt_d;
      missCnt_q   <= missCnt_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fillWe) begin
      dataArr_q[fillIdx][beatCnt_q] <= mem_rdata_i;
      if (lastBeat) begin
        tagArr_q[fillIdx] <= fillTag;
      end
    end
  end

endmodule

// File: tb/tb_icache_l1.sv
// Self-checking bench for icache_l1: directed refill scenarios plus random fetches
// compared against an array-based model of a direct-mapped cache.
module tb_icache_l1;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_read_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_out_o;
  logic        stallreq_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  always #5 clk = ~clk;

  icache_l1 #(.LINES(64), .WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .inst_read_i(inst_read_i), .inst_addr_i(inst_addr_i),
    .inst_out_o(inst_out_o), .stallreq_o(stallreq_o), .flush_i(flush_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  int checks = 0;
  int passes = 0;

  bit          modelValid [64];
  logic [21:0] modelTag   [64];
  logic [31:0] modelData  [64][4];
  logic [31:0] modelHits;
  logic [31:0] modelMisses;

  // Backing memory contents: the 0x100 line holds 0xA0..0xA3, everything else a hash.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'hA0 + 32'(a[3:2]);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) modelValid[i] = 1'b0;
    modelHits   = '0;
    modelMisses = '0;
  endtask

  task automatic modelFlush();
    for (int i = 0; i < 64; i++) modelValid[i] = 1'b0;
  endtask

  // Expected result of one fetch; a miss costs lookup + request wait + four beats with gaps.
  task automatic modelFetch(input logic [31:0] addr, input int gntDelay, input int gap,
                            input bit flushDuring, output logic [31:0] expInst,
                            output int expStall);
    int idx;
    logic [31:0] wordAddr;
    idx = int'(addr[9:4]);
    if (modelValid[idx] && modelTag[idx] == addr[31:10]) begin
      expInst   = modelData[idx][addr[3:2]];
      expStall  = 0;
      modelHits = modelHits + 32'd1;
    end else begin
      modelMisses = modelMisses + 32'd1;
      for (int k = 0; k < 4; k++) begin
        wordAddr = {addr[31:4], 4'b0000} + 32'(4 * k);
        modelData[idx][k] = memWord(wordAddr);
      end
      modelValid[idx] = 1'b1;
      modelTag[idx]   = addr[31:10];
      expInst  = modelData[idx][addr[3:2]];
      expStall = 2 + gntDelay + 4 * (gap + 1);
      if (flushDuring) modelFlush();
    end
  endtask

  // Drives one fetch and plays the memory side; returns what the CPU and memory saw.
  task automatic doFetch(input logic [31:0] addr, input int gntDelay, input int gap,
                         input int flushBeat, output logic [31:0] inst,
                         output int stallCycles, output logic [31:0] reqAddr,
                         output bit reqStable);
    int phase = 0;
    int reqWait = 0;
    int waitCnt = 0;
    int beatIdx = 0;
    bit flushed = 1'b0;
    bit running = 1'b1;
    inst = '0; stallCycles = 0; reqAddr = '0; reqStable = 1'b1;
    inst_read_i = 1'b1;
    inst_addr_i = addr;
    while (running) begin
      @(negedge clk);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; flush_i = 1'b0;
      if (!stallreq_o) begin
        inst = inst_out_o;
        running = 1'b0;
      end else begin
        stallCycles++;
        if (stallCycles > 300) begin
          running = 1'b0;
        end else if (phase == 2) begin
          if (flushBeat >= 0 && !flushed && beatIdx == flushBeat) begin
            flush_i = 1'b1;
            flushed = 1'b1;
          end
          if (beatIdx < 4) begin
            if (waitCnt < gap) begin
              waitCnt++;
            end else begin
              mem_rvalid_i = 1'b1;
              mem_rdata_i  = memWord({addr[31:4], 4'b0000} + 32'(4 * beatIdx));
              beatIdx++;
              waitCnt = 0;
            end
          end
        end else if (mem_req_o || phase == 1) begin
          if (phase == 0) begin
            reqAddr = mem_addr_o;
            phase   = 1;
          end else if (!mem_req_o || mem_addr_o !== reqAddr) begin
            reqStable = 1'b0;
          end
          if (reqWait >= gntDelay) begin
            mem_gnt_i = 1'b1;
            phase     = 2;
          end
          reqWait++;
        end
      end
    end
    @(posedge clk); #1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic idle(input int n);
    inst_read_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_read_i = 1'b0; inst_addr_i = '0; flush_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stallreq_o !== 1'b0) $display("[TB] FAIL reset_stall got %b want 0", stallreq_o); else passes++;
    checks++; if (mem_req_o !== 1'b0) $display("[TB] FAIL reset_memreq got %b want 0", mem_req_o); else passes++;
    checks++; if (mem_addr_o !== 32'h0) $display("[TB] FAIL reset_memaddr got %h want 0", mem_addr_o); else passes++;
    checks++; if (hit_cnt_o !== 32'h0 || miss_cnt_o !== 32'h0)
      $display("[TB] FAIL reset_counters got %h/%h want 0/0", hit_cnt_o, miss_cnt_o); else passes++;
    checks++; if (inst_out_o !== 32'h0) $display("[TB] FAIL reset_inst got %h want 0", inst_out_o); else passes++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    modelReset();
  endtask

  task automatic test_first_miss();
    logic [31:0] expInst, inst, reqAddr;
    int expStall, stall;
    bit stable;
    modelFetch(32'h100, 0, 0, 1'b0, expInst, expStall);
    doFetch(32'h100, 0, 0, -1, inst, stall, reqAddr, stable);
    checks++; if (inst !== expInst) $display("[TB] FAIL first_miss_inst got %h want %h", inst, expInst); else passes++;
    checks++; if (stall !== expStall) $display("[TB] FAIL first_miss_stall got %0d want %0d", stall, expStall); else passes++;
    checks++; if (reqAddr !== 32'h100) $display("[TB] FAIL first_miss_addr got %h want 00000100", reqAddr); else passes++;
    checks++; if (miss_cnt_o !== modelMisses) $display("[TB] FAIL first_miss_cnt got %0d want %0d", miss_cnt_o, modelMisses); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expInst, inst, reqAddr, addr;
    int expStall, stall;
    bit stable;
    for (int i = 1; i < 4; i++) begin
      addr = 32'h100 + 32'(4 * i);
      modelFetch(addr, 0, 0, 1'b0, expInst, expStall);
      doFetch(addr, 0, 0, -1, inst, stall, reqAddr, stable);
      checks++; if (inst !== expInst) $display("[TB] FAIL b2b_inst[%0d] got %h want %h", i, inst, expInst); else passes++;
      checks++; if (stall !== expStall) $display("[TB] FAIL b2b_stall[%0d] got %0d want %0d", i, stall, expStall); else passes++;
    end
    checks++; if (hit_cnt_o !== modelHits) $display("[TB] FAIL b2b_hitcnt got %0d want %0d", hit_cnt_o, modelHits); else passes++;
    idle(1);
    checks++; if (inst_out_o !== 32'h0 || stallreq_o !== 1'b0)
      $display("[TB] FAIL noread_outputs got %h/%b want 0/0", inst_out_o, stallreq_o); else passes++;
  endtask

  task automatic test_alias();
    logic [31:0] expInst, inst, reqAddr;
    int expStall, stall;
    bit stable;
    modelFetch(32'h500, 0, 0, 1'b0, expInst, expStall);
    doFetch(32'h500, 0, 0, -1, inst, stall, reqAddr, stable);
    checks++; if (reqAddr !== 32'h500) $display("[TB] FAIL alias_addr got %h want 00000500", reqAddr); else passes++;
    checks++; if (inst !== expInst) $display("[TB] FAIL alias_inst got %h want %h", inst, expInst); else passes++;
    modelFetch(32'h100, 0, 0, 1'b0, expInst, expStall);
    doFetch(32'h100, 0, 0, -1, inst, stall, reqAddr, stable);
    checks++; if (stall !== expStall) $display("[TB] FAIL alias_remiss_stall got %0d want %0d", stall, expStall); else passes++;
    checks++; if (inst !== expInst) $display("[TB] FAIL alias_remiss_inst got %h want %h", inst, expInst); else passes++;
    idle(1);
  endtask

  task automatic test_slow_memory();
    logic [31:0] expInst, inst, reqAddr, addr;
    int expStall, stall;
    bit stable;
    modelFetch(32'h2000, 3, 2, 1'b0, expInst, expStall);
    doFetch(32'h2000, 3, 2, -1, inst, stall, reqAddr, stable);
    checks++; if (stall !== expStall) $display("[TB] FAIL slow_stall got %0d want %0d", stall, expStall); else passes++;
    checks++; if (stable !== 1'b1) $display("[TB] FAIL slow_req_stable got %b want 1", stable); else passes++;
    checks++; if (reqAddr !== 32'h2000) $display("[TB] FAIL slow_addr got %h want 00002000", reqAddr); else passes++;
    checks++; if (inst !== expInst) $display("[TB] FAIL slow_inst got %h want %h", inst, expInst); else passes++;
    for (int i = 1; i < 4; i++) begin
      addr = 32'h2000 + 32'(4 * i);
      modelFetch(addr, 0, 0, 1'b0, expInst, expStall);
      doFetch(addr, 0, 0, -1, inst, stall, reqAddr, stable);
      checks++; if (inst !== expInst || stall !== expStall)
        $display("[TB] FAIL slow_order[%0d] got %h/%0d want %h/%0d", i, inst, stall, expInst, expStall); else passes++;
    end
    idle(1);
  endtask

  task automatic test_flush_fill();
    logic [31:0] expInst, inst, reqAddr;
    int expStall, stall;
    bit stable;
    modelFetch(32'h3008, 0, 0, 1'b1, expInst, expStall);
    doFetch(32'h3008, 0, 0, 1, inst, stall, reqAddr, stable);
    checks++; if (inst !== expInst) $display("[TB] FAIL flush_fill_inst got %h want %h", inst, expInst); else passes++;
    idle(1);
    modelFetch(32'h3008, 0, 0, 1'b0, expInst, expStall);
    doFetch(32'h3008, 0, 0, -1, inst, stall, reqAddr, stable);
    checks++; if (stall !== expStall) $display("[TB] FAIL flush_refetch_stall got %0d want %0d", stall, expStall); else passes++;
    modelFetch(32'h2004, 0, 0, 1'b0, expInst, expStall);
    doFetch(32'h2004, 0, 0, -1, inst, stall, reqAddr, stable);
    checks++; if (stall !== expStall || inst !== expInst)
      $display("[TB] FAIL flush_other_line got %h/%0d want %h/%0d", inst, stall, expInst, expStall); else passes++;
    idle(1);
  endtask

  task automatic test_reset_abort();
    logic [31:0] expInst, inst, reqAddr;
    int expStall, stall;
    bit stable;
    inst_read_i = 1'b1; inst_addr_i = 32'h4440;
    @(negedge clk);
    @(negedge clk); mem_gnt_i = 1'b1;
    @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = memWord(32'h4440);
    @(negedge clk); mem_rdata_i = memWord(32'h4444);
    @(negedge clk); mem_rvalid_i = 1'b0; inst_read_i = 1'b0; rst = 1'b1;
    #1;
    checks++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0)
      $display("[TB] FAIL abort_mem got %b/%h want 0/0", mem_req_o, mem_addr_o); else passes++;
    checks++; if (stallreq_o !== 1'b0 || miss_cnt_o !== 32'h0)
      $display("[TB] FAIL abort_state got %b/%0d want 0/0", stallreq_o, miss_cnt_o); else passes++;
    @(negedge clk); rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk); mem_rvalid_i = 1'b0;
    @(posedge clk); #1;
    modelReset();
    modelFetch(32'h4448, 0, 0, 1'b0, expInst, expStall);
    doFetch(32'h4448, 0, 0, -1, inst, stall, reqAddr, stable);
    checks++; if (stall !== expStall) $display("[TB] FAIL abort_refill_stall got %0d want %0d", stall, expStall); else passes++;
    checks++; if (inst !== expInst) $display("[TB] FAIL abort_refill_inst got %h want %h", inst, expInst); else passes++;
    checks++; if (miss_cnt_o !== modelMisses) $display("[TB] FAIL abort_misscnt got %0d want %0d", miss_cnt_o, modelMisses); else passes++;
    idle(1);
  endtask

  task automatic test_random();
    logic [31:0] expInst, inst, reqAddr, addr;
    int expStall, stall, gd, gp;
    bit stable;
    int bad = 0;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        inst_read_i = 1'b0; flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        modelFlush();
      end else begin
        addr = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4) |
               (32'($urandom_range(0, 3)) << 2);
        gd = $urandom_range(0, 2);
        gp = $urandom_range(0, 1);
        modelFetch(addr, gd, gp, 1'b0, expInst, expStall);
        doFetch(addr, gd, gp, -1, inst, stall, reqAddr, stable);
        checks++;
        if (inst !== expInst || stall !== expStall) begin
          bad++;
          if (bad < 6) $display("[TB] FAIL rand_fetch %h got %h/%0d want %h/%0d", addr, inst, stall, expInst, expStall);
        end else passes++;
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    idle(1);
    checks++; if (hit_cnt_o !== modelHits) $display("[TB] FAIL rand_hitcnt got %0d want %0d", hit_cnt_o, modelHits); else passes++;
    checks++; if (miss_cnt_o !== modelMisses) $display("[TB] FAIL rand_misscnt got %0d want %0d", miss_cnt_o, modelMisses); else passes++;
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_back_to_back();
    test_alias();
    test_slow_memory();
    test_flush_fill();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
